clmul_unit: RTL
===============

# clmul_unit

Parametrised, iterative carry-less multiply unit for the execute stage, implementing the Zbc operations CLMUL, CLMULH and CLMULR. It accepts one operation at a time over a valid/ready handshake and processes `BITS_PER_CYCLE` multiplier bits per clock. It returns an `XLEN`-bit result over a second valid/ready handshake. The pipeline can stall or flush it at any point.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; 32 or 64.
- `BITS_PER_CYCLE`, 8, multiplier bits consumed per RUN cycle; power of two, divides `XLEN`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request.
- `op`  in  2  funct3[1:0]: 01 CLMUL, 11 CLMULH, 10 CLMULR; 00 executes as CLMUL.
- `rs1`  in  `XLEN`  multiplicand A.
- `rs2`  in  `XLEN`  multiplier B.
- `stall`  in  1  freezes all state.
- `flush`  in  1  aborts the current operation.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  `XLEN`  registered result.
- `busy`  out  1  state is not IDLE.

## Operation
- N = `XLEN`/`BITS_PER_CYCLE`.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `in_valid && in_ready`. This edge latches A zero-extended to 2·`XLEN`, latches B and `op`, clears the accumulator, and loads `cnt` = N.
  - RUN, each edge:
    - acc ^= (A << i) for every i < `BITS_PER_CYCLE` with B[i] = 1.
    - A <<= `BITS_PER_CYCLE`; B >>= `BITS_PER_CYCLE`; `cnt` decrements.
    - When `cnt` == 1, go to DONE and register `result`.
  - DONE → IDLE on `out_ready`.
- `in_ready` = (state == IDLE) && !`stall` && !`flush`.
- Result select from the 2·`XLEN` product P:
  - CLMUL: P[`XLEN`-1:0].
  - CLMULH: P[2·`XLEN`-1:`XLEN`].
  - CLMULR: P[2·`XLEN`-2:`XLEN`-1].
- P[2·`XLEN`-1] is always 0.
- Priority: `reset` > `flush` > `stall` > normal.
- `flush`:
  - State goes to IDLE on that edge from any state, including DONE with a pending result.
  - `out_valid` is low the next cycle.
  - A request presented in the flush cycle is not accepted.
- `stall`:
  - No state, counter or datapath register changes.
  - `out_valid` and `result` are held.
  - A DONE result is not consumed even if `out_ready` = 1.
- Reset mid-operation discards all work with no result produced.
- Reset values: state IDLE, `out_valid` 0, `result` 0, `busy` 0, accumulator/A/B/`cnt` 0. `in_ready` becomes 1 in the first cycle after reset deasserts.

## Timing
- Request accepted at edge t. RUN occupies edges t+1 … t+N, and `out_valid` = 1 in the cycle after edge t+N. Latency is N+1 edges; each stalled cycle adds one.
- `out_valid` and `result` stay stable until the `out_ready` edge. The earliest next accept is the edge after the return to IDLE.
- Throughput is one operation per N+2 cycles under no backpressure.
- `result` comes from a register; there is no combinational path from inputs to outputs except `in_ready` (from `stall`/`flush`).

## Configuration
- `CLMUL_EARLY_OUT_EN` defined:
  - In RUN, if the shifted B after an edge is 0, go to DONE on that edge regardless of `cnt`.
  - `rs2` = 0 or `rs2` < 2^`BITS_PER_CYCLE` reaches DONE after edge t+1.
  - Results are identical to the undefined case.
- Undefined: fixed N-cycle RUN and no zero detect.

## Structure
- Package `clmul_pkg`:
  - `clmul_op_e` (CLMUL=2'b01, CLMULR=2'b10, CLMULH=2'b11).
  - `clmul_state_e` (IDLE, RUN, DONE).
- One sub-module, `clmul_step`: combinational, parametrised on `XLEN` and `BITS_PER_CYCLE`. It takes acc, A and the low B bits and returns the next acc. Instantiate it once.
- Result selection and the FSM live in `clmul_unit`.

## Test plan
Defaults `XLEN`=32, `BITS_PER_CYCLE`=8 (N=4), early-out undefined unless stated.
- CLMUL `rs1`=0x3, `rs2`=0x3, `out_ready`=1 → `result`=0x00000005, `out_valid` 5 edges after accept for exactly 1 cycle.
- CLMULH and CLMULR with `rs1`=`rs2`=0x80000000 → CLMULH `result`=0x40000000; CLMULR `result`=0x80000000.
- CLMUL `rs1`=0xFFFFFFFF, `rs2`=0xFFFFFFFF, `out_ready` held 0 for 3 cycles → `result`=0x55555555, held stable, `in_ready`=0 until consumed.
- `stall` for 2 cycles mid-RUN → `out_valid` delayed exactly 2 cycles, result unchanged; `flush` during RUN → IDLE next cycle, no `out_valid`, next request accepted normally.
- With `CLMUL_EARLY_OUT_EN`, CLMUL `rs1`=0x12345678, `rs2`=0x1 → `result`=0x12345678 with `out_valid` 2 edges after accept (5 without the macro).
- `reset` asserted in DONE with `out_valid`=1 → next cycle `out_valid`=0, `result`=0, `busy`=0.

Source files
------------

// File: rtl/clmul_pkg.sv
// Shared types for the iterative carry-less multiply unit (Zbc CLMUL/CLMULH/CLMULR).
package clmul_pkg;

   typedef enum logic [1:0] {
      CLMUL  = 2'b01,
      CLMULR = 2'b10,
      CLMULH = 2'b11
   } clmul_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } clmul_state_e;

endpackage

// File: rtl/clmul_step.sv
// One RUN iteration: folds BITS_PER_CYCLE partial products of the shifted
// multiplicand into the double-width carry-less accumulator.
module clmul_step
   import clmul_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 8
) (
   input  logic [2*XLEN-1:0]         acc_i,
   input  logic [2*XLEN-1:0]         a_i,
   input  logic [BITS_PER_CYCLE-1:0] b_lo_i,
   output logic [2*XLEN-1:0]         acc_o
);

   always_comb begin
      acc_o = acc_i;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (b_lo_i[i]) begin
            acc_o = acc_o ^ (a_i << i);
         end
      end
   end

endmodule

// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier with valid/ready in/out, stall and flush.
// Optional CLMUL_EARLY_OUT_EN ends RUN as soon as the remaining multiplier bits are zero.
module clmul_unit
   import clmul_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            stall,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   clmul_state_e      state_q, state_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2*XLEN-1:0] stepAcc;

   clmul_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .acc_i  (acc_q),
      .a_i    (a_q),
      .b_lo_i (b_q[BITS_PER_CYCLE-1:0]),
      .acc_o  (stepAcc)
   );

   // op 2'b00 is not a Zbc encoding and falls through to the CLMUL low half.
   function automatic logic [XLEN-1:0] selectResult(input logic [1:0] sel,
                                                    input logic [2*XLEN-1:0] prod);
      case (sel)
         CLMULH:  selectResult = prod[2*XLEN-1:XLEN];
         CLMULR:  selectResult = prod[2*XLEN-2:XLEN-1];
         default: selectResult = prod[XLEN-1:0];
      endcase
   endfunction

   assign in_ready  = (state_q == IDLE) && !stall && !flush;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (flush) begin
         state_d = IDLE;
      end else if (!stall) begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_d = RUN;
                  a_d     = {{XLEN{1'b0}}, rs1};
                  b_d     = rs2;
                  op_d    = op;
                  acc_d   = '0;
                  cnt_d   = CW'(N);
               end
            end
            RUN: begin
               acc_d = stepAcc;
               a_d   = a_q << BITS_PER_CYCLE;
               b_d   = b_q >> BITS_PER_CYCLE;
               cnt_d = cnt_q - CW'(1);
`ifdef CLMUL_EARLY_OUT_EN
               if ((cnt_q == CW'(1)) || (b_d == '0)) begin
`else
               if (cnt_q == CW'(1)) begin
`endif
                  state_d  = DONE;
                  result_d = selectResult(op_q, stepAcc);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

endmodule
